// File: rtl/sbqm_teller_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sbqm_teller_scheduler
//  Purpose  : Bank-queue controller. Detects arrivals on the entry photocell,
//             keeps the waiting count, grants the head customer to a free
//             teller round-robin, blocks the door when full and computes the
//             estimated wait time with a one-subtraction-per-cycle divider.
//  Revision : 1.0  initial release
// ============================================================================
module sbqm_teller_scheduler #(
    parameter int N_TELLERS = 3,
    parameter int CNT_W     = 3,
    parameter int SERVICE_T = 5,
    parameter int WT_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cust_in,
    input  logic [N_TELLERS-1:0] teller_ready,
    input  logic [N_TELLERS-1:0] teller_online,
    output logic [N_TELLERS-1:0] teller_grant,
    output logic [CNT_W-1:0]     pcount,
    output logic                 empty,
    output logic                 full,
    output logic                 entry_block,
    output logic                 overflow,
    output logic [WT_W-1:0]      wtime,
    output logic                 wtime_valid
);

    localparam int c_PTR_W  = (N_TELLERS > 1) ? $clog2(N_TELLERS) : 1;
    localparam int c_DEN_W  = $clog2(N_TELLERS + 1);
    localparam int c_NUM_W  = CNT_W + $clog2(SERVICE_T + 1);
    localparam int c_DIV_W  = (c_NUM_W > c_DEN_W) ? c_NUM_W : c_DEN_W;
    localparam int c_WT_MAX = (2 ** WT_W) - 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    // ------------------------------------------------------------------
    // Queue / arbitration state
    // ------------------------------------------------------------------
    logic                 r_cust_q;
    logic [CNT_W-1:0]     r_pcount;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_overflow;
    logic [N_TELLERS-1:0] r_grant;
    logic [c_PTR_W-1:0]   r_rr_ptr;

    logic                 w_arrival;
    logic                 w_acc;
    logic                 w_gnt;
    logic                 w_found;
    logic [N_TELLERS-1:0] w_eligible;
    logic [N_TELLERS-1:0] w_pick;
    logic [c_PTR_W-1:0]   w_idx;
    logic [c_PTR_W-1:0]   w_next_ptr;
    logic [CNT_W-1:0]     w_pcount_nxt;

    assign w_arrival = cust_in & ~r_cust_q;
    assign w_acc     = w_arrival & ~r_full;

    // Round-robin search for the first eligible teller starting at the pointer.
    // The teller granted last cycle is masked so one ready level is not served twice.
    always_comb begin
        w_eligible = teller_ready & ~r_grant;
        w_pick     = '0;
        w_found    = 1'b0;
        w_next_ptr = r_rr_ptr;
        w_idx      = '0;
        for (int k = 0; k < N_TELLERS; k++) begin
            w_idx = c_PTR_W'((int'(r_rr_ptr) + k) % N_TELLERS);
            if (!w_found && w_eligible[w_idx]) begin
                w_found      = 1'b1;
                w_pick[w_idx] = 1'b1;
                w_next_ptr   = c_PTR_W'((int'(w_idx) + 1) % N_TELLERS);
            end
        end
    end

    // Grants only leave a non-empty queue, so the count never underflows.
    assign w_gnt        = (r_pcount != '0) && w_found;
    assign w_pcount_nxt = r_pcount + CNT_W'(w_acc) - CNT_W'(w_gnt);

    // Queue count, flags, grant pulse and arbitration pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cust_q   <= 1'b1;
            r_pcount   <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_cust_q   <= cust_in;
            r_pcount   <= w_pcount_nxt;
            r_empty    <= (w_pcount_nxt == '0);
            r_full     <= (w_pcount_nxt == c_CNT_MAX);
            r_overflow <= w_arrival & r_full;
            r_grant    <= w_gnt ? w_pick : '0;
            if (w_gnt) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wait-time divider
    // ------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_W-1:0]     r_pc_last;
    logic [N_TELLERS-1:0] r_on_last;
    logic [c_DIV_W-1:0]   r_rem;
    logic [c_DIV_W-1:0]   r_den;
    logic [c_DIV_W-1:0]   r_q;
    logic [WT_W-1:0]      r_wtime;

    logic                 w_change;
    logic [c_DEN_W-1:0]   w_den;
    logic [c_DIV_W-1:0]   w_num;
    logic [c_DIV_W-1:0]   w_q_inc;
    logic                 w_last_step;

    assign w_change    = (r_pcount != r_pc_last) || (teller_online != r_on_last);
    assign w_num       = c_DIV_W'(r_pc_last) * c_DIV_W'(SERVICE_T);
    assign w_q_inc     = r_q + c_DIV_W'(1);
    assign w_last_step = (r_rem <= r_den);

    // Number of staffed tellers, the divisor.
    always_comb begin
        w_den = '0;
        for (int k = 0; k < N_TELLERS; k++) begin
            w_den = w_den + c_DEN_W'(teller_online[k]);
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: any input change restarts at LOAD, last change wins.
    always_comb begin
        w_state_nxt = r_state;
        if (w_change) begin
            w_state_nxt = c_ST_LOAD;
        end else begin
            case (r_state)
                c_ST_LOAD: w_state_nxt = ((w_den == '0) || (w_num == '0)) ? c_ST_IDLE : c_ST_DIV;
                c_ST_DIV:  w_state_nxt = w_last_step ? c_ST_IDLE : c_ST_DIV;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Result is current only while the divider is idle.
    always_comb begin
        wtime_valid = (r_state == c_ST_IDLE);
    end

    // Divider datapath; wtime keeps its old value until a division completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_last <= '0;
            r_on_last <= '0;
            r_rem     <= '0;
            r_den     <= '0;
            r_q       <= '0;
            r_wtime   <= '0;
        end else if (w_change) begin
            r_pc_last <= r_pcount;
            r_on_last <= teller_online;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    r_rem <= w_num;
                    r_den <= c_DIV_W'(w_den);
                    r_q   <= '0;
                    if (w_den == '0) begin
                        r_wtime <= {WT_W{1'b1}};
                    end else if (w_num == '0) begin
                        r_wtime <= '0;
                    end
                end
                c_ST_DIV: begin
                    if (w_last_step) begin
                        if (int'(w_q_inc) > c_WT_MAX) begin
                            r_wtime <= {WT_W{1'b1}};
                        end else begin
                            r_wtime <= WT_W'(w_q_inc);
                        end
                    end else begin
                        r_rem <= r_rem - r_den;
                        r_q   <= w_q_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign teller_grant = r_grant;
    assign pcount       = r_pcount;
    assign empty        = r_empty;
    assign full         = r_full;
    assign entry_block  = r_full;
    assign overflow     = r_overflow;
    assign wtime        = r_wtime;

endmodule
`default_nettype wire

// File: tb/tb_sbqm_teller_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbqm_teller_scheduler
//  Purpose  : Directed self-checking bench for sbqm_teller_scheduler with
//             hand-computed expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sbqm_teller_scheduler;

    logic       clk;
    logic       rst;
    logic       cust_in;
    logic [2:0] teller_ready;
    logic [2:0] teller_online;
    logic [2:0] teller_grant;
    logic [2:0] pcount;
    logic       empty;
    logic       full;
    logic       entry_block;
    logic       overflow;
    logic [5:0] wtime;
    logic       wtime_valid;

    int n_checks = 0;
    int n_pass   = 0;

    sbqm_teller_scheduler #(
        .N_TELLERS(3), .CNT_W(3), .SERVICE_T(5), .WT_W(6)
    ) u_dut (
        .clk(clk), .rst(rst), .cust_in(cust_in),
        .teller_ready(teller_ready), .teller_online(teller_online),
        .teller_grant(teller_grant), .pcount(pcount), .empty(empty),
        .full(full), .entry_block(entry_block), .overflow(overflow),
        .wtime(wtime), .wtime_valid(wtime_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive();
        cust_in = 1'b1;
        tick();
        cust_in = 1'b0;
        tick();
    endtask

    // One edge for the divider to leave IDLE, then wait for the result.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        tick();
        while (!wtime_valid && n < 100) begin
            tick();
            n++;
        end
        if (!wtime_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        cust_in       = 1'b1;
        teller_ready  = 3'b000;
        teller_online = 3'b000;
        do_reset();

        // Reset state; cust_in still high after reset is not an arrival
        tick();
        check("rst_pcount", pcount, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_block", entry_block, 0);
        check("rst_ovf", overflow, 0);
        check("rst_grant", teller_grant, 0);
        check("rst_wtime", wtime, 0);
        check("rst_valid", wtime_valid, 1);
        cust_in = 1'b0;
        teller_online = 3'b111;
        tick();

        // 1: three arrivals, 15/3 -> 5
        for (int i = 0; i < 3; i++) arrive();
        check("t1_pcount", pcount, 3);
        check("t1_empty", empty, 0);
        wait_valid("t1");
        check("t1_wtime", wtime, 5);

        // 2: fill to 7, then an eighth arrival overflows
        for (int i = 0; i < 4; i++) arrive();
        check("t2_pcount", pcount, 7);
        check("t2_full", full, 1);
        check("t2_block", entry_block, 1);
        wait_valid("t2");
        check("t2_wtime", wtime, 12);
        cust_in = 1'b1;
        tick();
        check("t2_ovf_hi", overflow, 1);
        check("t2_pcount_hold", pcount, 7);
        cust_in = 1'b0;
        tick();
        check("t2_ovf_lo", overflow, 0);

        // 3: four customers, all tellers ready -> 001,010,100,001
        do_reset();
        cust_in = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) arrive();
        check("t3_pcount", pcount, 4);
        teller_ready = 3'b111;
        tick(); check("t3_g0", teller_grant, 3'b001); check("t3_c0", pcount, 3);
        tick(); check("t3_g1", teller_grant, 3'b010); check("t3_c1", pcount, 2);
        tick(); check("t3_g2", teller_grant, 3'b100); check("t3_c2", pcount, 1);
        tick(); check("t3_g3", teller_grant, 3'b001); check("t3_c3", pcount, 0);
        tick(); check("t3_g4", teller_grant, 3'b000); check("t3_empty", empty, 1);
        tick(); check("t3_g5", teller_grant, 3'b000); check("t3_c5", pcount, 0);
        teller_ready = 3'b000;

        // 4: arrival and grant together at pcount=2
        arrive();
        arrive();
        check("t4_pcount", pcount, 2);
        cust_in      = 1'b1;
        teller_ready = 3'b001;
        tick();
        check("t4_grant", teller_grant, 3'b001);
        check("t4_pcount_same", pcount, 2);
        cust_in      = 1'b0;
        teller_ready = 3'b000;
        tick();
        check("t4_grant_off", teller_grant, 0);
        check("t4_pcount_after", pcount, 2);

        // 5: no tellers online -> saturate; then two online -> ceil(25/2)=13
        for (int i = 0; i < 3; i++) arrive();
        check("t5_pcount", pcount, 5);
        wait_valid("t5a");
        teller_online = 3'b000;
        wait_valid("t5b");
        check("t5_wtime_sat", wtime, 63);
        check("t5_valid_sat", wtime_valid, 1);
        teller_online = 3'b011;
        tick();
        check("t5_valid_lo", wtime_valid, 0);
        check("t5_wtime_hold", wtime, 63);
        n = 1;
        while (!wtime_valid && n < 100) begin
            tick();
            n++;
        end
        check("t5_latency", n, 15);
        check("t5_wtime", wtime, 13);

        // 6: reset in the middle of a division at pcount=6
        arrive();
        check("t6_pcount", pcount, 6);
        tick();
        tick();
        check("t6_busy", wtime_valid, 0);
        cust_in = 1'b1;
        rst     = 1'b1;
        tick();
        check("t6_pcount_rst", pcount, 0);
        check("t6_grant_rst", teller_grant, 0);
        check("t6_wtime_rst", wtime, 0);
        check("t6_valid_rst", wtime_valid, 1);
        rst = 1'b0;
        tick();
        check("t6_no_arrival", pcount, 0);
        tick();
        check("t6_no_arrival2", pcount, 0);
        cust_in = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
